// File: rtl/tick_counter_10000.sv
// tick_counter_10000: 0..9999 up/down counter advanced by a divided tick.
// A three-state FSM (STOP / RUN / CLEAR) gates the tick divider. The count is
// a registered output that changes one cycle after the internal tick, with
// o_tick marking that cycle.
//
// Handshake: there is no valid/ready pair. i_run_stop and i_clear are
// single-cycle pulses sampled on the rising clk edge; o_tick is a one-cycle
// strobe that qualifies a new o_count value.
module tick_counter_10000 #(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int TICK_HZ    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_run_stop,
    input  logic        i_clear,
    input  logic        i_mode,
    output logic [13:0] o_count,
    output logic        o_running,
    output logic        o_tick
);

    localparam int DIV   = SYS_CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(DIV - 1);
    localparam logic [13:0]      COUNT_MAX = 14'd9999;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [13:0]      count_q, count_d;
    logic             tick_q, tick_d;
    logic             tick_int;

    // Next-state logic: clear beats everything, CLEAR always falls to STOP
    // unless another clear pulse keeps it there.
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = ST_CLEAR;
        end else begin
            case (state_q)
                ST_STOP:  if (i_run_stop) state_d = ST_RUN;
                ST_RUN:   if (i_run_stop) state_d = ST_STOP;
                ST_CLEAR: state_d = ST_STOP;
                default:  state_d = ST_STOP;
            endcase
        end
    end

    // Divider advances only in RUN, holds in STOP (keeps phase across a
    // pause) and restarts from zero in CLEAR.
    always_comb begin
        div_d    = div_q;
        tick_int = 1'b0;
        case (state_q)
            ST_RUN: begin
                tick_int = (div_q == DIV_MAX);
                div_d    = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
            end
            ST_CLEAR: div_d = '0;
            default:  div_d = div_q;
        endcase
    end

    // Count update: mode is only looked at on a tick; CLEAR zeroes the count.
    always_comb begin
        count_d = count_q;
        tick_d  = tick_int;
        if (state_q == ST_CLEAR) begin
            count_d = '0;
        end else if (tick_int) begin
            if (i_mode) begin
                count_d = (count_q == 14'd0) ? COUNT_MAX : count_q - 14'd1;
            end else begin
                count_d = (count_q >= COUNT_MAX) ? 14'd0 : count_q + 14'd1;
            end
        end
    end

    // State, divider, count and tick strobe registers with async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOP;
            div_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign o_count   = count_q;
    assign o_tick    = tick_q;
    assign o_running = (state_q == ST_RUN);

endmodule

// File: tb/tb_tick_counter_10000.sv
// Bench for tick_counter_10000 with DIV = 10. Stimulus pushes the expected
// o_count value of every upcoming tick into exp_q; the monitor pops and
// compares each time o_tick is high, and also checks the tick spacing.
module tb_tick_counter_10000;

    logic        clk;
    logic        reset;
    logic        i_run_stop;
    logic        i_clear;
    logic        i_mode;
    logic [13:0] o_count;
    logic        o_running;
    logic        o_tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int prev_tick_cyc = 0;
    bit have_prev = 1'b0;
    logic [13:0] exp_q[$];

    tick_counter_10000 #(
        .SYS_CLK_HZ(100),
        .TICK_HZ   (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_run_stop(i_run_stop),
        .i_clear   (i_clear),
        .i_mode    (i_mode),
        .o_count   (o_count),
        .o_running (o_running),
        .o_tick    (o_tick)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every tick strobe consumes one expected value
    always @(negedge clk) begin
        if (!reset && o_tick) begin
            chk("count_in_range", int'(o_count <= 14'd9999), 1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tick actual=%0d expected=no_tick", o_count);
            end else begin
                chk("tick_count", int'(o_count), int'(exp_q.pop_front()));
            end
            if (have_prev) chk("tick_spacing", cyc - prev_tick_cyc, 10);
            have_prev     = 1'b1;
            prev_tick_cyc = cyc;
        end
    end

    // Driver helpers: inputs change 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        i_run_stop = 1'b1;
        step();
        i_run_stop = 1'b0;
    endtask

    task automatic push_range(input int first, input int last);
        for (int v = first; v <= last; v++) exp_q.push_back(14'(v));
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d_pending expected=0_pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int resume_cyc;
        int n;
        reset      = 1'b1;
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_mode     = 1'b0;
        repeat (3) step();
        chk("reset_count", int'(o_count), 0);
        chk("reset_running", int'(o_running), 0);
        chk("reset_tick", int'(o_tick), 0);
        reset = 1'b0;
        repeat (2) step();
        chk("idle_count", int'(o_count), 0);

        // Run up: ticks every 10 cycles giving 1, 2, 3
        push_range(1, 3);
        have_prev = 1'b0;
        pulse_run();
        chk("run_running", int'(o_running), 1);
        drain(50, "run_up");

        // Pause with the divider parked at 6, hold 50 cycles, resume
        repeat (5) step();
        pulse_run();
        have_prev = 1'b0;
        chk("stop_running", int'(o_running), 0);
        repeat (50) step();
        chk("stop_count_held", int'(o_count), 3);
        chk("stop_still_stopped", int'(o_running), 0);
        exp_q.push_back(14'd4);
        pulse_run();
        resume_cyc = cyc;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (o_tick) break;
        end
        if (!o_tick) begin
            checks++;
            failures++;
            $display("FAIL resume_tick_timeout actual=none expected=tick");
        end else begin
            chk("resume_tick_delay", cyc - resume_cyc, 4);
        end
        #1;

        // Count up to 57, then clear and run/stop in the same cycle
        push_range(5, 57);
        drain(600, "to_57");
        step();
        i_clear    = 1'b1;
        i_run_stop = 1'b1;
        step();
        i_clear    = 1'b0;
        i_run_stop = 1'b0;
        chk("clear_running", int'(o_running), 0);
        chk("clear_first_cycle_count", int'(o_count), 57);
        step();
        chk("clear_count_zero", int'(o_count), 0);
        chk("clear_then_stop_running", int'(o_running), 0);
        repeat (20) step();
        chk("stop_after_clear_count", int'(o_count), 0);

        // Down wrap from 0, then switch to up between ticks and wrap up
        i_mode = 1'b1;
        exp_q.push_back(14'd9999);
        exp_q.push_back(14'd9998);
        have_prev = 1'b0;
        pulse_run();
        chk("down_running", int'(o_running), 1);
        drain(40, "down_wrap");
        i_mode = 1'b0;
        exp_q.push_back(14'd9999);
        exp_q.push_back(14'd0);
        drain(40, "up_wrap");

        // Count up to 123, then async reset between clock edges
        push_range(1, 123);
        drain(1300, "to_123");
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_count", int'(o_count), 0);
        chk("async_reset_running", int'(o_running), 0);
        chk("async_reset_tick", int'(o_tick), 0);
        repeat (3) step();
        reset = 1'b0;
        repeat (15) step();
        chk("post_reset_count", int'(o_count), 0);
        chk("post_reset_running", int'(o_running), 0);

        // Normal operation resumes after reset
        exp_q.push_back(14'd1);
        have_prev = 1'b0;
        pulse_run();
        chk("post_reset_run", int'(o_running), 1);
        drain(30, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_counter_10000.md
TICK_COUNTER_10000 -- requirements
Module: tick_counter_10000

Interface
REQ-001 SHALL have parameter SYS_CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 10, count-advance rate in Hz; DIV = SYS_CLK_HZ/TICK_HZ, with DIV >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_run_stop  input  1  single-cycle pulse (already debounced) that toggles run/stop.
REQ-006 SHALL have port i_clear  input  1  single-cycle pulse that clears the count.
REQ-007 SHALL have port i_mode  input  1  count direction: 0 = up, 1 = down.
REQ-008 SHALL have port o_count  output  14  current count 0..9999, binary, driving the FND controller data input directly.
REQ-009 SHALL have port o_running  output  1  high while in RUN state.
REQ-010 SHALL have port o_tick  output  1  one-cycle pulse in the cycle o_count changes.

Function
REQ-011 SHALL implement FSM states STOP, RUN, CLEAR, encoded in 2 bits; the next-state logic SHALL be combinational and the state register SHALL be sequential.
REQ-012 SHALL go STOP->RUN on i_run_stop=1 and RUN->STOP on i_run_stop=1.
REQ-013 SHALL go from any state to CLEAR on i_clear=1; i_clear SHALL have priority over a simultaneous i_run_stop, which is ignored.
REQ-014 SHALL go CLEAR->STOP unconditionally after exactly one cycle; pulses arriving while in CLEAR SHALL be ignored, except that i_clear SHALL keep the FSM in CLEAR.
REQ-015 SHALL use a tick divider of width $clog2(DIV) that increments only in RUN, wraps at DIV-1, and asserts an internal tick in the cycle it is at DIV-1.
REQ-016 SHALL hold the divider value in STOP, so that pause/resume preserves phase; the divider SHALL reset to 0 in CLEAR.
REQ-017 SHALL update o_count one cycle after the internal tick, as a registered output.
REQ-018 SHALL pulse o_tick in that same cycle.
REQ-019 SHALL, on a tick with i_mode=0, count 9999 -> 0 (wrap) and otherwise add 1.
REQ-020 SHALL, on a tick with i_mode=1, count 0 -> 9999 (wrap) and otherwise subtract 1.
REQ-021 SHALL sample i_mode only in the cycle of the tick; mode changes between ticks SHALL have no other effect.
REQ-022 SHALL drive o_count to 0 one cycle after entering CLEAR and hold it at 0 through STOP until the next tick in RUN.
REQ-023 SHALL drive o_count from a 14-bit register that never takes a value above 9999.
REQ-024 SHALL assert o_running combinationally from state == RUN.
REQ-025 SHALL NOT advance o_count in STOP or CLEAR, regardless of divider value.
REQ-026 SHALL, when i_run_stop arrives in the same cycle as the internal tick while in RUN, still apply that tick and then enter STOP.

Reset
REQ-027 SHALL, on reset=1 at any time including mid-count, immediately set state=STOP, divider=0, o_count=0, o_tick=0, o_running=0.
REQ-028 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification (SYS_CLK_HZ=100, TICK_HZ=10, DIV=10)
REQ-029 SHALL verify reset then run: reset pulse, then i_run_stop pulse -> o_running=1; o_tick every 10 cycles; o_count 0,1,2,3 after 40 cycles.
REQ-030 SHALL verify up wrap: force count to 9998 via ticks (or a long run), i_mode=0 -> after two ticks o_count=0 with no value >9999 observed.
REQ-031 SHALL verify down wrap: from o_count=0, i_mode=1, RUN -> next tick o_count=9999, following tick 9998.
REQ-032 SHALL verify pause/resume: stop at divider=6, wait 50 cycles, resume -> o_count unchanged during stop; next tick 4 cycles after resume.
REQ-033 SHALL verify clear priority: i_clear and i_run_stop in the same cycle during RUN at o_count=57 -> CLEAR for 1 cycle, o_count=0, then STOP, o_running=0.
REQ-034 SHALL verify async reset mid-run: reset asserted between clock edges at o_count=123 -> o_count=0 and o_running=0 without waiting for a clk edge.
